// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI shift datapath.
package spi_pkg;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  // Bit-counter width able to hold the value WIDTH itself.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_en_arst.sv
// W-bit enabled register with asynchronous active-low reset to a parameter value.
module dff_en_arst #(
  parameter int unsigned      W           = 1,
  parameter logic [W-1:0]     RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RESET_VALUE;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/spi_shift_register.sv
// Parallel-load / serial-shift register with frame counter, done pulse and
// a holding register for the last completed received word.
module spi_shift_register
  import spi_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter bit               MSB_FIRST   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] pdata_in_i,
  input  logic             shift_en_i,
  input  logic             sin_i,
  output logic             sout_o,
  output logic [WIDTH-1:0] pdata_out_o,
  output logic [WIDTH-1:0] rx_word_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shifted;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             rx_en;

  if (MSB_FIRST) begin : g_msb
    assign sr_shifted = {sr_q[WIDTH-2:0], sin_i};
    assign sout_o     = sr_q[WIDTH-1];
  end else begin : g_lsb
    assign sr_shifted = {sin_i, sr_q[WIDTH-1:1]};
    assign sout_o     = sr_q[0];
  end

  // load beats shift_en and silently aborts any frame in flight.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rx_en   = 1'b0;
    if (load_i) begin
      sr_d    = pdata_in_i;
      cnt_d   = CntW'(WIDTH);
      state_d = StShift;
    end else if (state_q == StShift && shift_en_i) begin
      sr_d  = sr_shifted;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        state_d = StIdle;
        done_d  = 1'b1;
        rx_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= RESET_VALUE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  dff_en_arst #(
    .W           (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_rx_word (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (rx_en),
    .d_i   (sr_shifted),
    .q_o   (rx_word_o)
  );

  assign pdata_out_o = sr_q;
  assign busy_o      = (state_q == StShift);
  assign done_o      = done_q;

endmodule

// File: tb/tb_spi_shift_register.sv
// Directed bench: one MSB-first and one LSB-first 8-bit instance on shared controls.
module tb_spi_shift_register;

  logic       clk = 1'b0;
  logic       rst_n, load, shift_en, sin_m, sin_l;
  logic [7:0] pdata;

  logic       m_sout, m_busy, m_done, l_sout, l_busy, l_done;
  logic [7:0] m_pout, m_rx, l_pout, l_rx;

  int n_checks = 0;
  int n_errors = 0;
  int m_done_cnt = 0;
  int l_done_cnt = 0;

  always #5 clk = ~clk;

  spi_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1), .RESET_VALUE(8'h00)) dut_msb (
    .clk(clk), .rst_n(rst_n), .load_i(load), .pdata_in_i(pdata), .shift_en_i(shift_en),
    .sin_i(sin_m), .sout_o(m_sout), .pdata_out_o(m_pout), .rx_word_o(m_rx),
    .busy_o(m_busy), .done_o(m_done)
  );

  spi_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0), .RESET_VALUE(8'h00)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_i(load), .pdata_in_i(pdata), .shift_en_i(shift_en),
    .sin_i(sin_l), .sout_o(l_sout), .pdata_out_o(l_pout), .rx_word_o(l_rx),
    .busy_o(l_busy), .done_o(l_done)
  );

  always @(negedge clk) begin
    if (m_done) m_done_cnt++;
    if (l_done) l_done_cnt++;
  end

  typedef struct {
    logic       ld;
    logic [7:0] pd;
    logic       se;
    logic       si;
    logic       exp_sout;
    logic       exp_busy;
    logic       exp_done;
    logic [7:0] exp_pout;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_once(input logic bit_m, input logic bit_l);
    sin_m = bit_m;
    sin_l = bit_l;
    shift_en = 1'b1;
    cycle();
    shift_en = 1'b0;
  endtask

  initial begin
    logic [7:0] lsb_src, lsb_rx, abort_rx;
    int dc0;

    rst_n = 1'b0; load = 1'b0; shift_en = 1'b0; sin_m = 1'b0; sin_l = 1'b0; pdata = 8'h00;

    // MSB-first frame: load 0xA5, shift in 0x3C back-to-back.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4A, 8'h00};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h94, 8'h00};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h29, 8'h00};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h53, 8'h00};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA7, 8'h00};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4F, 8'h00};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h9E, 8'h00};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C};

    #12;
    check("reset_busy", {63'd0, m_busy}, 64'd0);
    check("reset_done", {63'd0, m_done}, 64'd0);
    check("reset_pout", {56'd0, m_pout}, 64'h00);
    check("reset_rx", {56'd0, m_rx}, 64'h00);
    check("reset_lsb_busy", {63'd0, l_busy}, 64'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 10; i++) begin
      load = tbl[i].ld;
      pdata = tbl[i].pd;
      shift_en = tbl[i].se;
      sin_m = tbl[i].si;
      sin_l = 1'b0;
      cycle();
      check($sformatf("msb_vec%0d_sout", i), {63'd0, m_sout}, {63'd0, tbl[i].exp_sout});
      check($sformatf("msb_vec%0d_busy", i), {63'd0, m_busy}, {63'd0, tbl[i].exp_busy});
      check($sformatf("msb_vec%0d_done", i), {63'd0, m_done}, {63'd0, tbl[i].exp_done});
      check($sformatf("msb_vec%0d_pout", i), {56'd0, m_pout}, {56'd0, tbl[i].exp_pout});
      check($sformatf("msb_vec%0d_rx", i), {56'd0, m_rx}, {56'd0, tbl[i].exp_rx});
    end
    load = 1'b0; shift_en = 1'b0;

    // LSB-first frame with two idle cycles between strobes.
    lsb_src = 8'hA5;
    lsb_rx = 8'h3C;
    load = 1'b1; pdata = lsb_src;
    cycle();
    load = 1'b0;
    check("lsb_load_busy", {63'd0, l_busy}, 64'd1);
    dc0 = l_done_cnt;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("lsb_sout%0d", k), {63'd0, l_sout}, {63'd0, lsb_src[k]});
      shift_once(1'b0, lsb_rx[k]);
      if (k < 7) begin
        check($sformatf("lsb_nodone%0d", k), {63'd0, l_done}, 64'd0);
        cycle();
        cycle();
      end
    end
    check("lsb_done", {63'd0, l_done}, 64'd1);
    check("lsb_busy_end", {63'd0, l_busy}, 64'd0);
    check("lsb_rx", {56'd0, l_rx}, 64'h3C);
    cycle();
    check("lsb_done_drop", {63'd0, l_done}, 64'd0);
    check("lsb_done_count", dc0 < 0 ? 64'd0 : 64'(l_done_cnt - dc0), 64'd1);

    // Abort by reload, then a full frame receiving 0x81.
    abort_rx = 8'h81;
    load = 1'b1; pdata = 8'hFF;
    cycle();
    load = 1'b0;
    for (int k = 0; k < 4; k++) shift_once(1'b0, 1'b0);
    dc0 = m_done_cnt;
    load = 1'b1; pdata = 8'h12;
    cycle();
    load = 1'b0;
    check("abort_sout", {63'd0, m_sout}, 64'd0);
    check("abort_pout", {56'd0, m_pout}, 64'h12);
    check("abort_busy", {63'd0, m_busy}, 64'd1);
    for (int k = 7; k >= 0; k--) shift_once(abort_rx[k], 1'b0);
    check("abort_done", {63'd0, m_done}, 64'd1);
    check("abort_rx", {56'd0, m_rx}, 64'h81);
    cycle();
    check("abort_done_count", 64'(m_done_cnt - dc0), 64'd1);

    // Load on the same edge as the final shift.
    load = 1'b1; pdata = 8'h00;
    cycle();
    load = 1'b0;
    dc0 = m_done_cnt;
    for (int k = 0; k < 7; k++) shift_once(1'b1, 1'b1);
    load = 1'b1; pdata = 8'h55; shift_en = 1'b1;
    cycle();
    load = 1'b0; shift_en = 1'b0;
    check("coll_done", {63'd0, m_done}, 64'd0);
    check("coll_rx", {56'd0, m_rx}, 64'h81);
    check("coll_busy", {63'd0, m_busy}, 64'd1);
    check("coll_pout", {56'd0, m_pout}, 64'h55);
    cycle();
    check("coll_done_count", 64'(m_done_cnt - dc0), 64'd0);

    // Asynchronous reset between edges after 5 shifts.
    load = 1'b1; pdata = 8'hC3;
    cycle();
    load = 1'b0;
    for (int k = 0; k < 5; k++) shift_once(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, m_busy}, 64'd0);
    check("arst_done", {63'd0, m_done}, 64'd0);
    check("arst_cnt", 64'(dut_msb.cnt_q), 64'd0);
    check("arst_rx", {56'd0, m_rx}, 64'h00);
    check("arst_pout", {56'd0, m_pout}, 64'h00);
    cycle();
    rst_n = 1'b1;

    // Idle shifting after reset is ignored.
    dc0 = m_done_cnt;
    for (int k = 0; k < 3; k++) begin
      shift_once(1'b1, 1'b1);
      cycle();
    end
    check("idle_pout", {56'd0, m_pout}, 64'h00);
    check("idle_rx", {56'd0, m_rx}, 64'h00);
    check("idle_busy", {63'd0, m_busy}, 64'd0);
    check("idle_done_count", 64'(m_done_cnt - dc0), 64'd0);

    // Load accepted on the first edge after reset release.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1; load = 1'b1; pdata = 8'h96;
    cycle();
    load = 1'b0;
    check("post_rst_busy", {63'd0, m_busy}, 64'd1);
    check("post_rst_pout", {56'd0, m_pout}, 64'h96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_shift_register.md
# spi_shift_register

Parametrised parallel-load / serial-shift register with frame counter, used by the SPI datapath to serialise multiplier operands and deserialise results. Generalises the single-bit and width-parametrised enabled flip-flops with:
- an asynchronous active-low reset;
- selectable shift direction;
- a bit counter that tracks a WIDTH-bit frame;
- a completion pulse;
- a holding register for the last complete received word.

## Interface
Parameters:
- WIDTH, 8: frame and register width in bits; legal range is 2 to 64.
- MSB_FIRST, 1: shift direction.
  - 1: shift left. sout is bit WIDTH-1 and sin enters at bit 0.
  - 0: shift right. sout is bit 0 and sin enters at bit WIDTH-1.
- RESET_VALUE, 0: value the shift register and rx_word take on reset.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: clock. All state updates on its rising edge.
  - rst_n, in, 1: asynchronous active-low reset.
- load, in, 1: parallel load request.
- pdata_in, in, WIDTH: parallel data, captured on load.
- shift_en, in, 1: one-bit shift strobe (the SPI sample edge qualifier).
- sin, in, 1: serial input.
- sout, out, 1: serial output, combinational from the current shift register.
- pdata_out, out, WIDTH: live shift register contents.
- rx_word, out, WIDTH: last completed frame, held until the next completion.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle pulse on frame completion.

## Operation
- States are IDLE and SHIFT. A bit counter bit_cnt, $clog2(WIDTH+1) bits wide, counts the shifts remaining in the frame.
- Reset (rst_n=0, applied immediately regardless of clk):
  - shift register = RESET_VALUE, rx_word = RESET_VALUE;
  - bit_cnt = 0, state = IDLE;
  - busy = 0, done = 0.
- load=1, in any state:
  - shift register ← pdata_in, bit_cnt ← WIDTH;
  - state ← SHIFT, done ← 0.
  - load has priority over shift_en. A frame in progress is aborted silently: no done pulse and no rx_word update.
- SHIFT with shift_en=1 and load=0:
  - the register shifts one position and sin fills the vacated end;
  - bit_cnt decrements by 1.
  - On the shift that takes bit_cnt from 1 to 0:
    - state ← IDLE;
    - rx_word ← the post-shift register value (all WIDTH sampled bits);
    - done ← 1 for exactly one cycle.
- IDLE with shift_en=1: ignored. Register, counter and rx_word are unchanged.
- SHIFT with shift_en=0: state is held indefinitely. There is no timeout.
- busy = (state == SHIFT), decoded directly from the state register.
- done is registered and deasserts on the next edge unless a new completion occurs.

## Timing
- Load: load sampled at edge N. From after edge N, busy=1 and sout presents the first bit (MSB or LSB of pdata_in, per MSB_FIRST).
- Shift: the k-th shift_en edge samples sin and advances sout to the next bit. Shift strobes may be back-to-back or spaced arbitrarily.
- Completion: the WIDTH-th shift edge M makes done=1, busy=0 and the new rx_word visible from after edge M until edge M+1. Minimum frame is WIDTH+1 cycles including the load.
- load on the same edge as the final shift: load wins. No done pulse; the new frame starts.
- Reset asserted mid-frame: immediate return to the reset values. Deasserting rst_n needs no cycle before load is accepted.

## Structure
- Shared package spi_pkg:
  - state enum (IDLE, SHIFT);
  - function cnt_w(WIDTH) returning $clog2(WIDTH+1).
- One sub-module, dff_en_arst:
  - parameter W, enable, asynchronous active-low reset to a parameter value;
  - instantiated for rx_word;
  - state, counter and shift register are coded in the top.

## Test plan
- Reset and idle shifting (WIDTH=8, RESET_VALUE=0): reset mid-operation, then pulse shift_en 3 times with no load → pdata_out=0x00, rx_word=0x00, busy=0, done never asserted.
- MSB-first frame (WIDTH=8, MSB_FIRST=1): load 0xA5, then 8 back-to-back shifts with sin=0x3C MSB-first →
  - sout sequence 1,0,1,0,0,1,0,1;
  - rx_word=0x3C, with done high for one cycle exactly after the 8th shift edge;
  - busy low from the same cycle.
- LSB-first frame (MSB_FIRST=0): load 0xA5, shift sin=0x3C LSB-first with 2 idle cycles between strobes → sout sequence 1,0,1,0,0,1,0,1 (LSB-first of 0xA5), rx_word=0x3C, single done pulse.
- Abort by reload: load 0xFF, 4 shifts, load 0x12, then 8 shifts of sin=0x81 →
  - exactly one done pulse;
  - rx_word=0x81;
  - sout after the reload starts at 0 (MSB of 0x12).
- Simultaneous load and final shift: on the 8th shift edge also assert load with 0x55 → done stays 0, rx_word keeps its previous value, busy stays 1, pdata_out=0x55.
- Asynchronous reset mid-frame: drop rst_n between edges after 5 shifts → busy, done and bit_cnt clear immediately without a clock edge; rx_word=RESET_VALUE.
